eq_scale_sequencer: RTL and testbench

Time-multiplexed gain/volume scheduler for the EQ datapath. After the five band filters (LP, B1, B2, B3, HP) produce a new left/right sample set, one shared signed multiplier is sequenced through all ten band-gain products and the two volume products. The per-channel sums are accumulated with saturation, and the final left/right output is presented with a one-cycle valid strobe. It replaces ten parallel band scalers, two volume multipliers and the combinational summing tree in the EQ engine.

---
 rtl/eq_pkg.sv | 37 +++
 rtl/eq_gain_mul.sv | 31 +++
 rtl/eq_scale_sequencer.sv | 157 +++++++++++++++
 tb/tb_eq_scale_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared types, constants and saturation helper for the EQ gain/volume sequencer.
package eq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    VOL,
    DONE
  } state_t;

  localparam int unsigned SMPL_BITS  = 16;
  localparam int unsigned GAIN_BITS  = 12;
  localparam int unsigned NUM_BANDS  = 5;
  localparam int unsigned ACC_W      = 19;
  localparam int unsigned GAIN_SHIFT = 11;
  // 16b signed sample x 13b signed (zero-extended gain) product width
  localparam int unsigned MUL_W      = SMPL_BITS + GAIN_BITS + 1;

  localparam logic [GAIN_BITS-1:0] UNITY_GAIN = 12'h800;

  localparam logic signed [MUL_W-1:0] SAT_MAX = 32767;
  localparam logic signed [MUL_W-1:0] SAT_MIN = -32768;

  // Clamp a wide signed value into the 16-bit signed sample range.
  function automatic logic signed [SMPL_BITS-1:0] sat16(input logic signed [MUL_W-1:0] x);
    logic signed [SMPL_BITS-1:0] r;
    if (x > SAT_MAX) begin
      r = 16'sh7fff;
    end else if (x < SAT_MIN) begin
      r = 16'sh8000;
    end else begin
      r = x[SMPL_BITS-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/eq_gain_mul.sv
// Registered signed sample x unsigned gain multiply, floor-scaled by 2^11 and saturated.
module eq_gain_mul
  import eq_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [SMPL_BITS-1:0] smpl,
  input  logic        [GAIN_BITS-1:0] gain,
  output logic signed [SMPL_BITS-1:0] prod
);

  logic signed [MUL_W-1:0] full;
  logic signed [MUL_W-1:0] shifted;

  // Gain is unsigned, so it enters the signed multiply with a zero sign bit.
  always_comb begin
    full    = MUL_W'(smpl) * MUL_W'($signed({1'b0, gain}));
    shifted = full >>> GAIN_SHIFT;
  end

  // Single pipeline stage; holds its value while not enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
    end else if (en) begin
      prod <= sat16(shifted);
    end
  end

endmodule

// File: rtl/eq_scale_sequencer.sv
// Time-multiplexed band-gain and volume scheduler sharing one multiplier.
module eq_scale_sequencer
  import eq_pkg::*;
#(
  parameter int unsigned GAIN_W = GAIN_BITS,
  parameter int unsigned SMPL_W = SMPL_BITS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [NUM_BANDS-1:0][SMPL_W-1:0]   lft_band,
  input  logic [NUM_BANDS-1:0][SMPL_W-1:0]   rht_band,
  input  logic [NUM_BANDS-1:0][GAIN_W-1:0]   band_gain,
  input  logic [GAIN_W-1:0]                  volume,
  output logic                               busy,
  output logic                               out_valid,
  output logic [SMPL_W-1:0]                  lft_out,
  output logic [SMPL_W-1:0]                  rht_out,
  output logic                               overrun
);

  localparam logic [3:0] LAST_STEP = 4'd9;

  state_t state, state_nxt;
  logic [3:0] step;

  logic [NUM_BANDS-1:0][SMPL_W-1:0] snap_l, snap_r;
  logic [NUM_BANDS-1:0][GAIN_W-1:0] snap_g;
  logic [GAIN_W-1:0]                snap_vol;

  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic                    acc_en, acc_left;

  logic [2:0]               band_idx;
  logic [SMPL_W-1:0]        opnd_smpl;
  logic [GAIN_W-1:0]        opnd_gain;
  logic signed [SMPL_W-1:0] prod;
  logic                     mul_en;
  logic                     accept;

  logic [SMPL_W-1:0] lft_q, rht_q;

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    overrun   = start && (state != IDLE) && !rst;
    case (state)
      IDLE:    if (start) state_nxt = SCALE;
      SCALE:   if (step == LAST_STEP) state_nxt = VOL;
      VOL:     if (step == 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Step counter: 0..9 through SCALE, reused as 0..1 through VOL.
  always_ff @(posedge clk) begin
    if (rst) begin
      step <= '0;
    end else if (state == SCALE && step != LAST_STEP) begin
      step <= step + 4'd1;
    end else if (state == VOL && step == 4'd0) begin
      step <= 4'd1;
    end else begin
      step <= '0;
    end
  end

  assign accept = (state == IDLE) && start;

  // Input snapshot taken on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_l   <= '0;
      snap_r   <= '0;
      snap_g   <= '0;
      snap_vol <= '0;
    end else if (accept) begin
      snap_l   <= lft_band;
      snap_r   <= rht_band;
      snap_g   <= band_gain;
      snap_vol <= volume;
    end
  end

  // Operand mux: band products in SCALE, then left/right volume in VOL.
  always_comb begin
    band_idx  = (step < 4'd5) ? step[2:0] : 3'(step - 4'd5);
    opnd_smpl = '0;
    opnd_gain = '0;
    mul_en    = (state == SCALE) || (state == VOL);
    if (state == SCALE) begin
      opnd_smpl = (step < 4'd5) ? snap_l[band_idx] : snap_r[band_idx];
      opnd_gain = snap_g[band_idx];
    end else if (state == VOL) begin
      opnd_smpl = (step == 4'd0) ? sat16({{(MUL_W-ACC_W){acc_l[ACC_W-1]}}, acc_l})
                                 : sat16({{(MUL_W-ACC_W){acc_r[ACC_W-1]}}, acc_r});
      opnd_gain = snap_vol;
    end
  end

  eq_gain_mul u_mul (
    .clk  (clk),
    .rst  (rst),
    .en   (mul_en),
    .smpl (opnd_smpl),
    .gain (opnd_gain),
    .prod (prod)
  );

  // The product register lags its step by one cycle, so SCALE steps 1..5 absorb
  // left products 0..4, steps 6..9 and VOL step 0 absorb right products 5..9.
  always_comb begin
    acc_en   = (state == SCALE && step != 4'd0) || (state == VOL && step == 4'd0);
    acc_left = (state == SCALE) && (step <= 4'd5);
  end

  // Per-channel accumulators, cleared on each accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_l <= '0;
      acc_r <= '0;
    end else if (accept) begin
      acc_l <= '0;
      acc_r <= '0;
    end else if (acc_en) begin
      if (acc_left) acc_l <= acc_l + {{(ACC_W-SMPL_W){prod[SMPL_W-1]}}, prod};
      else          acc_r <= acc_r + {{(ACC_W-SMPL_W){prod[SMPL_W-1]}}, prod};
    end
  end

  // Output capture: left from the product register during VOL step 1, right
  // is latched at the end of DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_q <= '0;
      rht_q <= '0;
    end else begin
      if (state == VOL && step == 4'd1) lft_q <= prod;
      if (state == DONE)                rht_q <= prod;
    end
  end

  // The right volume product lands in the (frozen) multiplier register on entry
  // to DONE; presenting it directly there keeps the 13-cycle latency.
  assign lft_out = lft_q;
  assign rht_out = (state == DONE) ? prod : rht_q;

endmodule

// File: tb/tb_eq_scale_sequencer.sv
// Scoreboard bench for eq_scale_sequencer.
module tb_eq_scale_sequencer;

  typedef struct {
    logic [4:0][15:0] l;
    logic [4:0][15:0] r;
    logic [4:0][11:0] g;
    logic [11:0]      v;
  } smp_t;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          due;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [4:0][15:0] lft_band;
  logic [4:0][15:0] rht_band;
  logic [4:0][11:0] band_gain;
  logic [11:0]      volume;
  logic             busy;
  logic             out_valid;
  logic [15:0]      lft_out;
  logic [15:0]      rht_out;
  logic             overrun;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          ov_count = 0;
  int          n_exp = 0;
  logic [15:0] last_l = '0;
  logic [15:0] last_r = '0;
  exp_t        sb[$];

  eq_scale_sequencer #(.GAIN_W(12), .SMPL_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lft_band  (lft_band),
    .rht_band  (rht_band),
    .band_gain (band_gain),
    .volume    (volume),
    .busy      (busy),
    .out_valid (out_valid),
    .lft_out   (lft_out),
    .rht_out   (rht_out),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: floor(x*g/2048) with 16-bit saturation at every stage.
  function automatic longint sat(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint scl(input logic [15:0] s, input logic [11:0] g);
    longint p;
    p = longint'($signed(s)) * longint'(g);
    return sat(p >>> 11);
  endfunction

  function automatic logic [15:0] chan(input logic [4:0][15:0] b, input logic [4:0][11:0] g,
                                       input logic [11:0] v);
    longint sum;
    logic [15:0] a;
    sum = 0;
    for (int i = 0; i < 5; i++) sum += scl(b[i], g[i]);
    a = 16'(sat(sum));
    return 16'(scl(a, v));
  endfunction

  function automatic smp_t mk(input logic [15:0] lb, input logic [15:0] rb,
                              input logic [11:0] gg, input logic [11:0] vv);
    smp_t s;
    for (int i = 0; i < 5; i++) begin
      s.l[i] = lb;
      s.r[i] = rb;
      s.g[i] = gg;
    end
    s.v = vv;
    return s;
  endfunction

  task automatic apply(input smp_t s);
    lft_band  = s.l;
    rht_band  = s.r;
    band_gain = s.g;
    volume    = s.v;
  endtask

  // Drive an accepted start (current cycle = cycle 0) and queue its expectation.
  task automatic send(input smp_t s);
    exp_t e;
    e.l   = chan(s.l, s.g, s.v);
    e.r   = chan(s.r, s.g, s.v);
    e.due = cyc + 13;
    sb.push_back(e);
    n_exp++;
    apply(s);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Walk cycles 1..14 of a transaction, optionally firing a start at ovr_at.
  task automatic run_cycles(input int ovr_at, input smp_t alt);
    for (int k = 1; k <= 14; k++) begin
      if (k == ovr_at) begin
        apply(alt);
        start = 1'b1;
      end
      @(negedge clk);
      check($sformatf("busy_c%0d", k), {31'b0, busy}, (k <= 13) ? 32'd1 : 32'd0);
      check($sformatf("overrun_c%0d", k), {31'b0, overrun}, (k == ovr_at) ? 32'd1 : 32'd0);
      if (k == 6) begin
        check("hold_lft", {16'b0, lft_out}, {16'b0, last_l});
        check("hold_rht", {16'b0, rht_out}, {16'b0, last_r});
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (out_valid) begin
      exp_t e;
      ov_count++;
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("lft_out", {16'b0, lft_out}, {16'b0, e.l});
        check("rht_out", {16'b0, rht_out}, {16'b0, e.r});
        check("latency", cyc, e.due);
        last_l = e.l;
        last_r = e.r;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    smp_t s_unity, s_pos, s_neg, s_floor, s_mix, none;
    s_unity = mk(16'h0100, 16'h0100, 12'h800, 12'h800);
    s_pos   = mk(16'h7000, 16'h7000, 12'hFFF, 12'h800);
    s_neg   = mk(16'h8000, 16'h8000, 12'h800, 12'h800);
    s_floor = mk(16'h0000, 16'h0000, 12'h400, 12'h800);
    s_floor.l[0] = 16'hFFFF;
    s_floor.r[0] = 16'h0001;
    s_mix   = mk(16'h1000, 16'h0000, 12'h800, 12'h400);
    none    = mk(16'h0000, 16'h0000, 12'h000, 12'h000);

    rst = 1'b1;
    start = 1'b0;
    apply(none);

    // Reset, with a start held during it that must be ignored.
    @(posedge clk); #1;
    start = 1'b1;
    apply(s_unity);
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);
    check("rst_lft", {16'b0, lft_out}, 32'd0);
    check("rst_rht", {16'b0, rht_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("start_in_rst_ignored", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;

    // Main function under distinct patterns.
    send(s_unity); run_cycles(0, none);
    send(s_pos);   run_cycles(0, none);
    send(s_neg);   run_cycles(0, none);
    send(s_floor); run_cycles(0, none);
    send(s_mix);   run_cycles(0, none);

    // Overrun: second start at cycle 5 with different data is dropped.
    send(s_unity); run_cycles(5, s_mix);

    // Reset mid-operation abandons the sample.
    send(s_pos);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_back());
    n_exp--;
    last_l = '0;
    last_r = '0;
    @(negedge clk);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_lft", {16'b0, lft_out}, 32'd0);
    check("midrst_rht", {16'b0, rht_out}, 32'd0);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    send(s_mix); run_cycles(0, none);

    repeat (3) @(posedge clk);
    #1;
    check("out_valid_count", ov_count, n_exp);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
